ppm_sram_loader: RTL

Upstream stage of the SRAM image buffer. Consumes the byte stream from the UART receiver carrying a binary PPM file. Strips the text header, packs payload bytes big-endian into 16-bit words, and writes them to consecutive SRAM addresses. Declares the transfer finished after a configurable idle timeout, which returns the top level to its IDLE/VGA mode.

---
 rtl/ppm_sram_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ppm_sram_loader.sv
// PPM-to-SRAM loader: drops the text header of a received PPM stream, packs payload
// bytes big-endian into 16-bit words and writes them to consecutive SRAM addresses.
module ppm_sram_loader #(
    parameter int unsigned HEADER_LINES   = 3,
    parameter logic [17:0] BASE_ADDR      = 18'd0,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned MAX_WORDS      = 262144
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start_i,
    input  logic [7:0]  RX_data_i,
    input  logic        RX_valid_i,
    output logic [17:0] SRAM_address_o,
    output logic [15:0] SRAM_write_data_o,
    output logic        SRAM_we_n_o,
    output logic        Busy_o,
    output logic        Done_o,
    output logic        Overflow_o,
    output logic [17:0] Word_count_o
);

    localparam int unsigned LW = $clog2(HEADER_LINES + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LW-1:0] LAST_LINE  = LW'(HEADER_LINES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [18:0]   MAX_W      = 19'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]  hi_q, hi_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [18:0] count_q, count_d;
    logic        flush_q, flush_d;

    logic timeout;
    logic full;

    assign timeout = (timer_q == TIMER_LAST) && !RX_valid_i;
    // A write in flight has not yet been added to count_q, so include it here.
    assign full    = (count_q + {18'b0, ~we_n_q}) >= MAX_W;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            timer_q <= '0;
            hi_q    <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            timer_q <= timer_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start_i) state_d = (HEADER_LINES == 0) ? S_HIGH : S_HEADER;
            end
            S_HEADER: begin
                if (RX_valid_i) begin
                    if (RX_data_i == 8'h0A && line_q == LAST_LINE) state_d = S_HIGH;
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_HIGH: begin
                if (RX_valid_i) begin
                    if (!full) state_d = S_LOW;
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_LOW: begin
                // A timeout here stays one extra cycle to flush the odd trailing byte.
                if (flush_q) state_d = S_DONE;
                else if (RX_valid_i) state_d = S_HIGH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        line_d  = line_q;
        timer_d = timer_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        ovf_d   = ovf_q;
        count_d = count_q;
        flush_d = 1'b0;

        if (!we_n_q) begin
            count_d = count_q + 19'd1;
            if (addr_q != '1) addr_d = addr_q + 18'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start_i) begin
                    line_d  = '0;
                    timer_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                end
            end
            S_HEADER: begin
                timer_d = RX_valid_i ? '0 : timer_q + 1'b1;
                if (RX_valid_i && RX_data_i == 8'h0A) line_d = line_q + 1'b1;
            end
            S_HIGH: begin
                timer_d = RX_valid_i ? '0 : timer_q + 1'b1;
                if (RX_valid_i) begin
                    if (full) ovf_d = 1'b1;
                    else      hi_d  = RX_data_i;
                end
            end
            S_LOW: begin
                timer_d = RX_valid_i ? '0 : timer_q + 1'b1;
                if (!flush_q) begin
                    if (RX_valid_i) begin
                        we_n_d  = 1'b0;
                        wdata_d = {hi_q, RX_data_i};
                    end else if (timeout) begin
                        we_n_d  = 1'b0;
                        wdata_d = {hi_q, 8'h00};
                        flush_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d == S_HEADER) || (state_d == S_HIGH) || (state_d == S_LOW);
        done_d = (state_d == S_DONE);
    end

    assign SRAM_address_o    = addr_q;
    assign SRAM_write_data_o = wdata_q;
    assign SRAM_we_n_o       = we_n_q;
    assign Busy_o            = busy_q;
    assign Done_o            = done_q;
    assign Overflow_o        = ovf_q;
    assign Word_count_o      = count_q[17:0];

endmodule
